multicycle_control: RTL

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/ctrl_pkg.sv | 62 ++++++
 rtl/opcode_decoder.sv | 30 +++
 rtl/multicycle_control.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// -----------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the multicycle control unit:
//   - state_t    : FSM state encoding (also driven out on the 'state' port)
//   - iclass_t   : instruction class produced by opcode_decoder
//   - OP_*       : recognized 7-bit opcodes
//   - ALUOP_*    : aluop encodings seen by the datapath ALU
//   - CAUSE_*    : trap_cause codes
//   - exec_alu() : aluop/alusrc selection for a given instruction class
// -----------------------------------------------------------------------------
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CLS_NONE   = 3'd0,
        CLS_R      = 3'd1,
        CLS_I      = 3'd2,
        CLS_LOAD   = 3'd3,
        CLS_STORE  = 3'd4,
        CLS_BRANCH = 3'd5
    } iclass_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_SUB    = 2'b01;
    localparam logic [1:0] ALUOP_RFUNCT = 2'b10;
    localparam logic [1:0] ALUOP_IFUNCT = 2'b11;

    localparam logic [1:0] CAUSE_NONE        = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL     = 2'b01;
    localparam logic [1:0] CAUSE_MEM_TIMEOUT = 2'b10;

    // Returns {aluop, alusrc} for the EXEC stage of a class; WB reuses it so
    // the ALU result stays stable while it is written back.
    function automatic logic [2:0] exec_alu(input iclass_t cls);
        logic [2:0] sel;
        sel = {ALUOP_ADD, 1'b0};
        case (cls)
            CLS_R:      sel = {ALUOP_RFUNCT, 1'b0};
            CLS_I:      sel = {ALUOP_IFUNCT, 1'b1};
            CLS_LOAD:   sel = {ALUOP_ADD,    1'b1};
            CLS_STORE:  sel = {ALUOP_ADD,    1'b1};
            CLS_BRANCH: sel = {ALUOP_SUB,    1'b0};
            default:    sel = {ALUOP_ADD,    1'b0};
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/opcode_decoder.sv
// -----------------------------------------------------------------------------
// opcode_decoder
// Purely combinational map from a 7-bit opcode to an instruction class.
// Ports:
//   opcode  in  [6:0]  instruction[6:0]
//   iclass  out        decoded class (CLS_NONE when not recognized)
//   illegal out        1 when the opcode is not one of the five classes
// -----------------------------------------------------------------------------
module opcode_decoder
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output iclass_t    iclass,
    output logic       illegal
);

    always_comb begin
        iclass  = CLS_NONE;
        illegal = 1'b0;
        case (opcode)
            OP_R:      iclass = CLS_R;
            OP_I:      iclass = CLS_I;
            OP_LOAD:   iclass = CLS_LOAD;
            OP_STORE:  iclass = CLS_STORE;
            OP_BRANCH: iclass = CLS_BRANCH;
            default:   illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
// Control FSM for a multicycle datapath: FETCH -> DECODE -> EXEC -> (MEM) ->
// (WB) -> FETCH, with a sticky TRAP state for illegal opcodes and data-memory
// timeouts, plus a retired-instruction counter.
// Parameters:
//   MEM_TIMEOUT  number of MEM cycles without dmem_ready before trapping
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   run               start strobe, only looked at in FETCH
//   opcode [6:0]      live instruction[6:0], captured in DECODE
//   dmem_ready        data memory completion strobe
//   alusrc, mem2reg, regwrite, memread, memwrite, branch, writepc
//                     datapath control lines
//   aluop [1:0]       00 add, 01 sub/compare, 10 R funct, 11 I funct
//   state [2:0]       current FSM state
//   trap              sticky fault flag
//   trap_cause [1:0]  00 none, 01 illegal opcode, 10 memory timeout
//   instret [31:0]    retired instruction count (one per writepc pulse)
// -----------------------------------------------------------------------------
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [6:0]  opcode,
    input  logic        dmem_ready,
    output logic        alusrc,
    output logic        mem2reg,
    output logic        regwrite,
    output logic        memread,
    output logic        memwrite,
    output logic        branch,
    output logic        writepc,
    output logic [1:0]  aluop,
    output logic [2:0]  state,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [31:0] instret
);

    // The watchdog only has to hold 0 .. MEM_TIMEOUT-1.
    localparam int                WD_W    = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WD_W-1:0]   WD_LAST = WD_W'(MEM_TIMEOUT - 1);

    state_t          state_q;
    logic [6:0]      ir_op_q;
    logic [WD_W-1:0] wdog_q;
    logic            trap_q;
    logic [1:0]      cause_q;
    logic [31:0]     instret_q;

    iclass_t live_cls;
    logic    live_illegal;
    iclass_t ir_cls;
    logic    ir_illegal;
    logic    live_cls_unused;

    // Live opcode is only trusted in DECODE; everything afterwards works from
    // the captured ir_op so the datapath may change instruction[6:0] freely.
    opcode_decoder u_dec_live (
        .opcode  (opcode),
        .iclass  (live_cls),
        .illegal (live_illegal)
    );

    opcode_decoder u_dec_ir (
        .opcode  (ir_op_q),
        .iclass  (ir_cls),
        .illegal (ir_illegal)
    );

    // DECODE only needs the legality verdict of the live opcode.
    assign live_cls_unused = ^live_cls;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            ir_op_q   <= '0;
            wdog_q    <= '0;
            trap_q    <= 1'b0;
            cause_q   <= CAUSE_NONE;
            instret_q <= '0;
        end else begin
            if (writepc) begin
                instret_q <= instret_q + 32'd1;
            end
            case (state_q)
                ST_FETCH: begin
                    if (run) begin
                        state_q <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    ir_op_q <= opcode;
                    if (live_illegal) begin
                        state_q <= ST_TRAP;
                        trap_q  <= 1'b1;
                        cause_q <= CAUSE_ILLEGAL;
                    end else begin
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // Clearing here means every MEM visit starts its count at 0.
                    wdog_q <= '0;
                    case (ir_cls)
                        CLS_LOAD, CLS_STORE: state_q <= ST_MEM;
                        CLS_R, CLS_I:        state_q <= ST_WB;
                        default:             state_q <= ST_FETCH;
                    endcase
                end
                ST_MEM: begin
                    // dmem_ready is tested first so it wins over the timeout.
                    if (dmem_ready) begin
                        state_q <= (ir_cls == CLS_LOAD) ? ST_WB : ST_FETCH;
                    end else if (wdog_q == WD_LAST) begin
                        state_q <= ST_TRAP;
                        trap_q  <= 1'b1;
                        cause_q <= CAUSE_MEM_TIMEOUT;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                ST_WB: begin
                    state_q <= ST_FETCH;
                end
                ST_TRAP: begin
                    state_q <= ST_TRAP;
                end
                default: begin
                    state_q <= ST_FETCH;
                end
            endcase
        end
    end

    // Control lines decode from the registered state and ir_op only. The one
    // exception is the STORE completion writepc, which must coincide with the
    // dmem_ready cycle so the store retires without an extra state. Reset
    // forces every line low immediately.
    always_comb begin
        alusrc   = 1'b0;
        mem2reg  = 1'b0;
        regwrite = 1'b0;
        memread  = 1'b0;
        memwrite = 1'b0;
        branch   = 1'b0;
        writepc  = 1'b0;
        aluop    = ALUOP_ADD;
        if (!reset && !ir_illegal) begin
            case (state_q)
                ST_EXEC: begin
                    {aluop, alusrc} = exec_alu(ir_cls);
                    if (ir_cls == CLS_BRANCH) begin
                        branch  = 1'b1;
                        writepc = 1'b1;
                    end
                end
                ST_MEM: begin
                    aluop    = ALUOP_ADD;
                    alusrc   = 1'b1;
                    memread  = (ir_cls == CLS_LOAD);
                    memwrite = (ir_cls == CLS_STORE);
                    writepc  = (ir_cls == CLS_STORE) && dmem_ready;
                end
                ST_WB: begin
                    {aluop, alusrc} = exec_alu(ir_cls);
                    regwrite = 1'b1;
                    writepc  = 1'b1;
                    mem2reg  = (ir_cls == CLS_LOAD);
                end
                default: begin
                end
            endcase
        end
    end

    assign state      = state_q;
    assign trap       = trap_q;
    assign trap_cause = cause_q;
    assign instret    = instret_q;

endmodule
